stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of byte-source channels, 2..8.
REQ-002 Parameter DATA_W, default 8: bits per channel word.
REQ-003 Parameter FIFO_DEPTH, default 4: words per channel FIFO, power of two, 2..64.
REQ-004 Parameter MODE, default 0: 0 = fixed priority (ch0 highest); 1 = round-robin.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 din  input  NUM_CH*DATA_W  channel words; ch k occupies bits [k*DATA_W +: DATA_W].
REQ-008 dinValid  input  NUM_CH  one-cycle write strobe per channel; there is no input backpressure.
REQ-009 dout  output  DATA_W  arbitrated word.
REQ-010 doutValid  output  1  dout holds a valid word.
REQ-011 doutReady  input  1  consumer accepts dout when doutValid&doutReady at the clock edge.
REQ-012 doutChannel  output  clog2(NUM_CH), min 1  source channel index of dout.
REQ-013 overflowErr  output  NUM_CH  sticky per-channel overflow flags.
REQ-014 errClear  input  1  synchronous clear of all overflowErr bits.

Function
REQ-015 Each channel SHALL have its own FIFO_DEPTH FIFO; a dinValid pulse writes din slice when the FIFO is not full.
REQ-016 A write to a full FIFO SHALL drop the word, leave FIFO contents unchanged and set overflowErr[k].
REQ-017 A write to a full FIFO in the same cycle that the arbiter pops that FIFO SHALL be accepted with no error.
REQ-018 errClear SHALL clear overflowErr; a new overflow in the same cycle as errClear SHALL win and leave the bit set.
REQ-019 The output stage SHALL be a single register (dout, doutChannel, doutValid).
REQ-020 The output register SHALL load when it is empty, or when it is popped (doutValid&doutReady), and any FIFO is non-empty.
REQ-021 Sustained throughput SHALL be one word per clock.
REQ-022 Latency: a word written to an empty FIFO at edge N, with an empty output register and no competitors, SHALL show doutValid=1 after edge N+1.
REQ-023 While doutValid=1 and doutReady=0, dout and doutChannel SHALL stay stable.
REQ-024 MODE 0: the grant SHALL go to the lowest-index non-empty FIFO.
REQ-025 MODE 1: the grant SHALL go to the first non-empty FIFO searching upward, with wrap, from pointer rrPtr.
REQ-026 MODE 1: after each grant, rrPtr SHALL become (granted+1) mod NUM_CH; with no grant, rrPtr SHALL hold.
REQ-027 Per-channel word order SHALL be preserved; no word SHALL be duplicated or lost except by REQ-016.
REQ-028 FIFO pointers SHALL be clog2(FIFO_DEPTH)+1 bits, with full/empty from MSB compare; wrap SHALL be silent.
REQ-029 When the output is popped and all FIFOs are empty, doutValid SHALL fall on the next edge.

Reset
REQ-030 resetn low SHALL immediately set: all FIFOs empty; doutValid=0; dout=0; doutChannel=0; overflowErr=0; rrPtr=0.
REQ-031 Reset mid-transfer SHALL discard all buffered words; the first write after deassertion SHALL behave as from power-up.
REQ-032 FIFO storage arrays SHALL need no reset.

Structure
REQ-033 Package stream_arbiter_pkg SHALL hold the MODE_FIXED=0 and MODE_RR=1 constants and the clog2 helper function.
REQ-034 Per-channel FIFO SHALL be sub-module byte_fifo (params DATA_W, FIFO_DEPTH; ports wr/rd/full/empty), generated NUM_CH times.
REQ-035 Arbiter and output register SHALL live in stream_arbiter; target size is 150-300 lines total.

Verification
REQ-036 MODE 0, NUM_CH=2, doutReady=1: same-cycle writes ch0=0x41, ch1=0x42 -> dout 0x41/ch0 on edge 1, then 0x42/ch1 on edge 2.
REQ-037 MODE 1, NUM_CH=3, all FIFOs hold 2 words, doutReady=1 -> grant order ch0,ch1,ch2,ch0,ch1,ch2.
REQ-038 FIFO_DEPTH=4, doutReady=0: 6 writes on ch1 (0x10..0x15) -> overflowErr[1]=1; after release, dout 0x10..0x14 only (the output register holds 0x10, the FIFO holds 0x11..0x14, 0x15 dropped).
REQ-039 Hold doutReady=0 for 10 cycles with doutValid=1 -> dout/doutChannel constant; the first word follows on the doutReady=1 edge.
REQ-040 Assert resetn=0 mid-stream with 3 words buffered -> doutValid=0 immediately; no stale word after release; the next write 0x55 appears at latency 1.
REQ-041 Same-cycle errClear and overflow on ch0 -> overflowErr[0] stays 1; a later errClear alone clears it.

Source files
------------

// File: rtl/stream_arbiter_pkg.sv
// Shared constants and helpers for the stream arbiter slice.
// Arbitration mode selectors and a constant-foldable ceil(log2) used for pointer widths.
package stream_arbiter_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock FIFO for one source channel of the stream arbiter.
// A write to a full FIFO is accepted only when the same cycle also pops it.
module byte_fifo
    import stream_arbiter_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rd,
    output logic [DATA_W-1:0] rdData,
    output logic              full,
    output logic              empty
);

    localparam int AW = clog2(FIFO_DEPTH);

    logic [AW:0]       wrPtr;
    logic [AW:0]       rdPtr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              doRead;
    logic              doWrite;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doRead  = rd && !empty;
    assign doWrite = wr && (!full || doRead);
    assign rdData  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + (AW+1)'(1);
            end
            if (doRead) begin
                rdPtr <= rdPtr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Merges NUM_CH buffered byte streams into one registered output stream,
// using fixed-priority or round-robin selection among non-empty channel FIFOs.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = MODE_FIXED,
    localparam int CH_W      = (NUM_CH > 2) ? clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CH*DATA_W-1:0] din,
    input  logic [NUM_CH-1:0]        dinValid,
    output logic [DATA_W-1:0]        dout,
    output logic                     doutValid,
    input  logic                     doutReady,
    output logic [CH_W-1:0]          doutChannel,
    output logic [NUM_CH-1:0]        overflowErr,
    input  logic                     errClear
);

    logic [NUM_CH-1:0] fifoEmpty;
    logic [NUM_CH-1:0] fifoFull;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] ovfNew;
    logic [DATA_W-1:0] fifoData [NUM_CH];
    logic [CH_W-1:0]   rrPtr;
    logic [CH_W-1:0]   rrNext;
    logic [CH_W-1:0]   grant;
    logic              granted;
    logic              load;

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        byte_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) uFifo (
            .clk    (clk),
            .resetn (resetn),
            .wr     (dinValid[k]),
            .wrData (din[k*DATA_W +: DATA_W]),
            .rd     (pop[k]),
            .rdData (fifoData[k]),
            .full   (fifoFull[k]),
            .empty  (fifoEmpty[k])
        );

        assign pop[k] = load && (grant == CH_W'(k));
    end

    // Two passes give a wrapping search from the start index without modulo arithmetic.
    always_comb begin
        int startIdx;
        startIdx = (MODE == MODE_RR) ? int'(rrPtr) : 0;
        grant    = '0;
        granted  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!granted && !fifoEmpty[i] && (i >= startIdx)) begin
                grant   = CH_W'(i);
                granted = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!granted && !fifoEmpty[i]) begin
                grant   = CH_W'(i);
                granted = 1'b1;
            end
        end
    end

    assign rrNext = (int'(grant) == NUM_CH - 1) ? '0 : grant + CH_W'(1);
    assign load   = granted && (!doutValid || doutReady);
    // A pop in the same cycle frees the slot, so that write is not an overflow.
    assign ovfNew = dinValid & fifoFull & ~pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout        <= '0;
            doutChannel <= '0;
            doutValid   <= 1'b0;
            overflowErr <= '0;
            rrPtr       <= '0;
        end else begin
            overflowErr <= (errClear ? '0 : overflowErr) | ovfNew;
            if (load) begin
                dout        <= fifoData[grant];
                doutChannel <= grant;
                doutValid   <= 1'b1;
                rrPtr       <= rrNext;
            end else if (doutReady) begin
                doutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: a fixed-priority 2-channel instance (A) and a
// round-robin 3-channel instance (B) checked against a queue-level model every cycle.
module tb_stream_arbiter;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic        errClear = 1'b0;

    logic [15:0] dinA = '0;
    logic [1:0]  dvA  = '0;
    logic        rdyA = 1'b0;
    logic [7:0]  doutA;
    logic        validA;
    logic [0:0]  chA;
    logic [1:0]  ovfA;

    logic [23:0] dinB = '0;
    logic [2:0]  dvB  = '0;
    logic        rdyB = 1'b0;
    logic [7:0]  doutB;
    logic        validB;
    logic [1:0]  chB;
    logic [2:0]  ovfB;

    int checks = 0;
    int passes = 0;

    int rrExpCh [6] = '{0, 1, 2, 0, 1, 2};
    int rrExpD  [6] = '{'h01, 'h11, 'h21, 'h02, 'h12, 'h22};
    int drainExp[4] = '{'h62, 'h63, 'h64, 'h77};

    always #5 clk = ~clk;

    stream_arbiter #(.NUM_CH(2), .DATA_W(8), .FIFO_DEPTH(4), .MODE(0)) dutA (
        .clk(clk), .resetn(resetn), .din(dinA), .dinValid(dvA), .dout(doutA),
        .doutValid(validA), .doutReady(rdyA), .doutChannel(chA),
        .overflowErr(ovfA), .errClear(errClear)
    );

    stream_arbiter #(.NUM_CH(3), .DATA_W(8), .FIFO_DEPTH(4), .MODE(1)) dutB (
        .clk(clk), .resetn(resetn), .din(dinB), .dinValid(dvB), .dout(doutB),
        .doutValid(validB), .doutReady(rdyB), .doutChannel(chB),
        .overflowErr(ovfB), .errClear(errClear)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: per-channel circular queues of depth 4, one output slot, rr pointer.
    logic [7:0] mMem [2][3][4];
    int         mCnt [2][3];
    int         mHead[2][3];
    int         mCh  [2];
    int         mRr  [2];
    bit         mValid[2];
    logic [7:0] mData[2];
    logic [2:0] mOvf [2];

    always @(posedge clk or negedge resetn) begin
        int n;
        int g;
        int c;
        bit rdy;
        bit ld;
        logic [2:0]  wv;
        logic [2:0]  newOvf;
        logic [7:0]  wd;
        logic [23:0] dinAx;
        if (!resetn) begin
            for (int u = 0; u < 2; u++) begin
                mValid[u] = 0;
                mData[u]  = '0;
                mCh[u]    = 0;
                mRr[u]    = 0;
                mOvf[u]   = '0;
                for (int k = 0; k < 3; k++) begin
                    mCnt[u][k]  = 0;
                    mHead[u][k] = 0;
                end
            end
        end else begin
            dinAx = {8'h00, dinA};
            for (int u = 0; u < 2; u++) begin
                n   = (u == 0) ? 2 : 3;
                rdy = (u == 0) ? rdyA : rdyB;
                wv  = (u == 0) ? {1'b0, dvA} : dvB;
                g   = -1;
                for (int i = 0; i < n; i++) begin
                    c = (u == 1) ? (mRr[u] + i) % n : i;
                    if (g < 0 && mCnt[u][c] > 0) g = c;
                end
                ld = (g >= 0) && (!mValid[u] || rdy);
                if (ld) begin
                    mData[u]    = mMem[u][g][mHead[u][g]];
                    mHead[u][g] = (mHead[u][g] + 1) % 4;
                    mCnt[u][g]  = mCnt[u][g] - 1;
                    mValid[u]   = 1;
                    mCh[u]      = g;
                    mRr[u]      = (g + 1) % n;
                end else if (rdy) begin
                    mValid[u] = 0;
                end
                newOvf = '0;
                for (int k = 0; k < n; k++) begin
                    wd = (u == 0) ? dinAx[k*8 +: 8] : dinB[k*8 +: 8];
                    if (wv[k]) begin
                        if (mCnt[u][k] < 4) begin
                            mMem[u][k][(mHead[u][k] + mCnt[u][k]) % 4] = wd;
                            mCnt[u][k] = mCnt[u][k] + 1;
                        end else begin
                            newOvf[k] = 1'b1;
                        end
                    end
                end
                mOvf[u] = (errClear ? 3'b000 : mOvf[u]) | newOvf;
            end
        end
    end

    always @(negedge clk) begin
        chk("model A valid", int'(validA), int'(mValid[0]));
        if (mValid[0]) begin
            chk("model A dout", int'(doutA), int'(mData[0]));
            chk("model A chan", int'(chA), mCh[0]);
        end
        chk("model A ovf", int'(ovfA), int'(mOvf[0]));
        chk("model B valid", int'(validB), int'(mValid[1]));
        if (mValid[1]) begin
            chk("model B dout", int'(doutB), int'(mData[1]));
            chk("model B chan", int'(chB), mCh[1]);
        end
        chk("model B ovf", int'(ovfB), int'(mOvf[1]));
    end

    initial begin
        resetn = 1'b0;
        repeat (2) tick();
        chk("rst A valid", int'(validA), 0);
        chk("rst A dout", int'(doutA), 0);
        chk("rst A chan", int'(chA), 0);
        chk("rst A ovf", int'(ovfA), 0);
        chk("rst B valid", int'(validB), 0);
        resetn = 1'b1;
        tick();

        // Fixed priority, simultaneous writes on both channels.
        rdyA = 1'b1;
        dinA = 16'h4241;
        dvA  = 2'b11;
        tick();
        dvA = '0;
        chk("t1 not yet valid", int'(validA), 0);
        tick();
        chk("t1 first dout", int'(doutA), 'h41);
        chk("t1 first chan", int'(chA), 0);
        tick();
        chk("t1 second dout", int'(doutA), 'h42);
        chk("t1 second chan", int'(chA), 1);
        tick();
        chk("t1 valid falls", int'(validA), 0);

        // Round robin over three channels, two words each.
        rdyB = 1'b1;
        dinB = 24'h211101;
        dvB  = 3'b111;
        tick();
        dinB = 24'h221202;
        tick();
        dvB = '0;
        for (int i = 0; i < 6; i++) begin
            chk("t2 rr dout", int'(doutB), rrExpD[i]);
            chk("t2 rr chan", int'(chB), rrExpCh[i]);
            tick();
        end
        chk("t2 valid falls", int'(validB), 0);

        // Overflow on channel 1 while output stalled.
        rdyA = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dinA = 16'((16'h10 + i) << 8);
            dvA  = 2'b10;
            tick();
        end
        dvA = '0;
        chk("t3 ovf set", int'(ovfA), 2);
        chk("t3 held dout", int'(doutA), 'h10);
        rdyA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3 drain dout", int'(doutA), 'h10 + i);
            chk("t3 drain chan", int'(chA), 1);
            tick();
        end
        chk("t3 no dropped word", int'(validA), 0);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        chk("t3 ovf cleared", int'(ovfA), 0);

        // Stall stability for 10 cycles.
        rdyA = 1'b0;
        dinA = 16'h5AA5;
        dvA  = 2'b11;
        tick();
        dvA = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4 hold dout", int'(doutA), 'hA5);
            chk("t4 hold chan", int'(chA), 0);
            tick();
        end
        rdyA = 1'b1;
        tick();
        chk("t4 next dout", int'(doutA), 'h5A);
        chk("t4 next chan", int'(chA), 1);
        tick();
        chk("t4 valid falls", int'(validA), 0);

        // Reset mid-stream with three words buffered on B.
        rdyB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dinB = 24'(8'h31 + i);
            dvB  = 3'b001;
            tick();
        end
        dvB = '0;
        tick();
        chk("t5 buffered valid", int'(validB), 1);
        #2 resetn = 1'b0;
        #1;
        chk("t5 async valid", int'(validB), 0);
        chk("t5 async dout", int'(doutB), 0);
        chk("t5 async chan", int'(chB), 0);
        tick();
        resetn = 1'b1;
        rdyB   = 1'b1;
        tick();
        chk("t5 no stale", int'(validB), 0);
        dinB = 24'h000055;
        dvB  = 3'b001;
        tick();
        dvB = '0;
        chk("t5 not yet valid", int'(validB), 0);
        tick();
        chk("t5 fresh dout", int'(doutB), 'h55);
        chk("t5 fresh chan", int'(chB), 0);
        chk("t5 fresh valid", int'(validB), 1);
        tick();
        chk("t5 valid falls", int'(validB), 0);

        // Overflow coinciding with errClear, then write-while-popping a full FIFO.
        rdyA = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dinA     = 16'(8'h60 + i);
            dvA      = 2'b01;
            errClear = (i == 5);
            tick();
        end
        dvA      = '0;
        errClear = 1'b0;
        chk("t6 overflow wins", int'(ovfA), 1);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        chk("t6 clear alone", int'(ovfA), 0);
        rdyA = 1'b1;
        dinA = 16'h0077;
        dvA  = 2'b01;
        tick();
        dvA = '0;
        chk("t6 pop+write no ovf", int'(ovfA), 0);
        chk("t6 pop dout", int'(doutA), 'h61);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6 drain dout", int'(doutA), drainExp[i]);
        end
        tick();
        chk("t6 valid falls", int'(validA), 0);

        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
